if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage feeding the main decoder (Ctr).
//   - Holds the PC, drives the instruction-memory address, computes PC+4.
//   - Selects the next PC from sequential, branch and jump sources.
//   - Registers the fetched word into the IF/ID pipeline register;
//     opCode = ifidInstr[31:26] is the decoder input.
//   - Supports stall (hold) and flush (bubble) for the 5-stage MIPS pipeline.
// PARAMETERS
//   PC_WIDTH   32            width of PC, addresses and instruction word
//   RESET_PC   32'h0000_0000 PC value loaded by reset
//   CNT_WIDTH  32            width of fetch counter (board display)
// PORTS
//   clk           in   1         rising-edge clock
//   reset         in   1         synchronous, active-high
//   stall         in   1         hazard unit: hold PC and IF/ID
//   branchTaken   in   1         branch resolved taken (branch & zero, from EX)
//   branchTarget  in   PC_WIDTH  branch destination address
//   jump          in   1         jump decoded in ID (Ctr.jump)
//   jumpIndex     in   26        instr[25:0] of the jump in ID
//   imemData      in   32        instruction word at imemAddr (combinational read)
//   imemAddr      out  PC_WIDTH  = pc
//   pc            out  PC_WIDTH  current fetch PC
//   ifidInstr     out  32        IF/ID instruction register
//   ifidPcPlus4   out  PC_WIDTH  IF/ID PC+4 of that instruction
//   ifidValid     out  1         IF/ID holds a real instruction (0 = bubble)
//   opCode        out  6         ifidInstr[31:26], to Ctr
//   fetchCount    out  CNT_WIDTH count of instructions accepted into IF/ID
// BEHAVIOUR
//   Reset values (sync, overrides everything):
//     pc=RESET_PC; ifidInstr=32'h0; ifidPcPlus4=0; ifidValid=0; fetchCount=0.
//   Latency: word at imemAddr in cycle N appears on ifidInstr/opCode in N+1.
//   pcPlus4 = pc + 4, modulo 2^PC_WIDTH (32'hFFFF_FFFC wraps to 0).
//   jumpTarget = {ifidPcPlus4[31:28], jumpIndex, 2'b00}.
//   Next-PC priority, evaluated per edge:
//     1. reset        -> RESET_PC
//     2. branchTaken  -> {branchTarget[31:2],2'b00}; IF/ID flushed
//     3. jump         -> jumpTarget; IF/ID flushed
//     4. stall        -> pc held; IF/ID held; fetchCount held
//     5. otherwise    -> pcPlus4; IF/ID <= {imemData, pcPlus4}, ifidValid=1
//   Flush: ifidInstr=32'h0 (NOP, opCode 000000 with rd=0), ifidValid=0,
//     ifidPcPlus4=0; fetchCount not incremented.
//   branchTaken and jump together: branch wins (older instruction).
//   Redirect overrides stall in the same cycle (redirect kills the stalled slot).
//   fetchCount increments by 1 only in case 5; wraps at 2^CNT_WIDTH.
//   Target bits [1:0] are forced to 0; pc is always word-aligned.
//   No internal FSM beyond the PC/IF-ID registers; all outputs registered
//     except imemAddr (=pc) and opCode (slice of ifidInstr).
// STRUCTURE
//   Shared header mips_defs.vh: NOP_INSTR=32'h0, RESET_PC default, opcode
//     constants OP_RTYPE 000000, OP_J 000010, OP_LW 100011, OP_SW 101011,
//     OP_BEQ 000100 (also used by Ctr).
//   One sub-module: ifid_reg (instr, pcPlus4, valid with load/flush/hold).
//   Next-PC mux and counter live in if_stage.
// TESTING
//   1. reset high 2 cycles, release -> pc=0, imemAddr 0,4,8,...; ifidValid=1
//      from cycle after release; fetchCount=1,2,3.
//   2. sequential fetch of 8C010004 (lw) -> next cycle ifidInstr=8C010004,
//      opCode=100011, ifidPcPlus4=pc+4.
//   3. branchTaken=1, branchTarget=32'h0000_0043 -> pc=32'h40 next cycle,
//      ifidInstr=0, ifidValid=0, fetchCount unchanged.
//   4. jump=1, jumpIndex=26'h0000010, ifidPcPlus4=32'h1000_0008
//      -> pc=32'h1000_0040, IF/ID flushed.
//   5. stall=1 for 3 cycles -> pc, ifidInstr, fetchCount constant;
//      stall=1 with branchTaken=1 -> redirect taken.
//   6. pc=32'hFFFF_FFFC, no redirect -> pc=0; reset asserted mid-stall
//      -> all outputs at reset values next edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared MIPS fetch definitions: opcodes, NOP encoding, next-PC source selector
// and helpers for target alignment.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Source of the next PC, listed from highest to lowest priority after reset.
  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_HOLD   = 2'd2,
    SEL_SEQ    = 2'd3
  } pc_sel_e;

  function automatic pc_sel_e pick_pc_source(input logic branch_taken,
                                             input logic jump,
                                             input logic stall);
    if (branch_taken)  return SEL_BRANCH;
    else if (jump)     return SEL_JUMP;
    else if (stall)    return SEL_HOLD;
    else               return SEL_SEQ;
  endfunction

  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // J-type target: upper nibble of the delay-slot PC+4, then index, then 00.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4,
                                            input logic [25:0] index);
    return (pc_plus4 & 32'hF000_0000) | {4'h0, index, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid bit,
// with reset > flush > load > hold priority.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                flush,
  input  logic [31:0]         instr_in,
  input  logic [PC_WIDTH-1:0] pc_plus4_in,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_plus4_out,
  output logic                valid_out
);

  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      // A bubble is an all-zero word so the decoder sees sll $0,$0,0.
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (branch/jump/stall/
// sequential), IF/ID register and a count of instructions accepted into IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branchTaken,
  input  logic [PC_WIDTH-1:0]  branchTarget,
  input  logic                 jump,
  input  logic [25:0]          jumpIndex,
  input  logic [31:0]          imemData,
  output logic [PC_WIDTH-1:0]  imemAddr,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [31:0]          ifidInstr,
  output logic [PC_WIDTH-1:0]  ifidPcPlus4,
  output logic                 ifidValid,
  output logic [5:0]           opCode,
  output logic [CNT_WIDTH-1:0] fetchCount
);

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [PC_WIDTH-1:0]  pc_plus4;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  jump_target;
  pc_sel_e              pc_sel;
  logic                 ifid_load;
  logic                 ifid_flush;

  // Natural modulo wrap: 32'hFFFF_FFFC + 4 becomes 0.
  assign pc_plus4      = pc_q + PC_WIDTH'(4);
  assign branch_target = PC_WIDTH'(word_align(32'(branchTarget)));
  assign jump_target   = PC_WIDTH'(jump_addr(32'(ifidPcPlus4), jumpIndex));

  assign pc_sel     = pick_pc_source(branchTaken, jump, stall);
  assign ifid_flush = is_redirect(pc_sel);
  assign ifid_load  = (pc_sel == SEL_SEQ);

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    unique case (pc_sel)
      SEL_BRANCH: pc_d = branch_target;
      SEL_JUMP:   pc_d = jump_target;
      SEL_HOLD:   pc_d = pc_q;
      SEL_SEQ: begin
        pc_d    = pc_plus4;
        count_d = count_q + CNT_WIDTH'(1);
      end
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  ifid_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_ifid_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (ifid_load),
    .flush        (ifid_flush),
    .instr_in     (imemData),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (ifidInstr),
    .pc_plus4_out (ifidPcPlus4),
    .valid_out    (ifidValid)
  );

  assign pc         = pc_q;
  assign imemAddr   = pc_q;
  assign opCode     = ifidInstr[31:26];
  assign fetchCount = count_q;

endmodule
